// File: rtl/neuron_layer_sequencer_if.sv
// Handshake and datapath bundle between a layer sequencer, its upstream/downstream
// stages, the weight memory and the shared Neuron datapath.
interface neuron_layer_sequencer_if #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned NUM_INPUTS  = 192,
  parameter int unsigned NUM_NEURONS = 10,
  parameter int unsigned ADDR_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
);
  localparam int unsigned IN_W  = DATA_WIDTH * NUM_INPUTS;
  localparam int unsigned OUT_W = DATA_WIDTH * NUM_NEURONS;

  logic                  in_valid;
  logic                  in_ready;
  logic [IN_W-1:0]       in_data;
  logic [IN_W-1:0]       neu_data;
  logic                  wmem_en;
  logic [ADDR_W-1:0]     wmem_addr;
  logic [DATA_WIDTH-1:0] neu_result;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      out_data;
  logic                  busy;

  // Sequencer side
  modport slave (
    input  in_valid, in_data, neu_result, out_ready,
    output in_ready, neu_data, wmem_en, wmem_addr, out_valid, out_data, busy
  );

  // Environment side: upstream producer, weight memory, Neuron, downstream consumer
  modport master (
    output in_valid, in_data, neu_result, out_ready,
    input  in_ready, neu_data, wmem_en, wmem_addr, out_valid, out_data, busy
  );
endinterface

// File: rtl/neuron_layer_sequencer.sv
// Time-multiplexes one shared Neuron datapath across all neurons of a
// fully-connected layer: latches an input vector, streams weight-row reads,
// collects each neuron result into an output vector and hands it downstream.
module neuron_layer_sequencer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned NUM_INPUTS  = 192,
  parameter int unsigned NUM_NEURONS = 10,
  parameter int unsigned NEURON_LAT  = 0,
  parameter int unsigned ADDR_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  neuron_layer_sequencer_if.slave       bus
);
  localparam int unsigned IN_W  = DATA_WIDTH * NUM_INPUTS;
  localparam int unsigned OUT_W = DATA_WIDTH * NUM_NEURONS;
  // Memory read (1) plus registered Neuron stages
  localparam int unsigned DEPTH = NEURON_LAT + 1;
  // Wide enough to hold NUM_NEURONS itself without wrapping
  localparam int unsigned CNT_W = $clog2(NUM_NEURONS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_NEURONS - 1);
  localparam logic [CNT_W-1:0] ALL_CNT  = CNT_W'(NUM_NEURONS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              wmem_en_q, wmem_en_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  issue_idx_q, issue_idx_d;
  logic [CNT_W-1:0]  cap_cnt_q, cap_cnt_d;
  logic [IN_W-1:0]   neu_data_q, neu_data_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;

  // Capture pipeline: valid bit and neuron index travel alongside the read
  logic [DEPTH-1:0]  pipe_v_q, pipe_v_d;
  logic [ADDR_W-1:0] pipe_i_q [DEPTH];
  logic [ADDR_W-1:0] pipe_i_d [DEPTH];

  logic              cap_fire_c;
  logic [ADDR_W-1:0] cap_idx_c;
  logic [CNT_W-1:0]  cap_cnt_next_c;
  logic              accept_c;

  assign cap_fire_c     = pipe_v_q[DEPTH-1];
  assign cap_idx_c      = pipe_i_q[DEPTH-1];
  assign cap_cnt_next_c = cap_cnt_q + CNT_W'(cap_fire_c);

  // Sequencing FSM: next state and registered-output next values
  always_comb begin
    state_d     = state_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    wmem_en_d   = 1'b0;
    issue_idx_d = '0;
    neu_data_d  = neu_data_q;
    accept_c    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (in_ready_q && bus.in_valid) begin
          accept_c    = 1'b1;
          neu_data_d  = bus.in_data;
          in_ready_d  = 1'b0;
          wmem_en_d   = 1'b1;
          issue_idx_d = '0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (issue_idx_q == LAST_IDX) begin
          state_d = S_DRAIN;
        end else begin
          wmem_en_d   = 1'b1;
          issue_idx_d = issue_idx_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cap_cnt_next_c == ALL_CNT) begin
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        // in_ready stays low for the first IDLE cycle: no same-cycle bypass
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Capture pipeline shift and result collection into the output vector
  always_comb begin
    pipe_v_d[0] = wmem_en_q;
    pipe_i_d[0] = ADDR_W'(issue_idx_q);
    for (int k = 1; k < int'(DEPTH); k++) begin
      pipe_v_d[k] = pipe_v_q[k-1];
      pipe_i_d[k] = pipe_i_q[k-1];
    end

    out_data_d = out_data_q;
    for (int n = 0; n < int'(NUM_NEURONS); n++) begin
      if (cap_fire_c && (cap_idx_c == ADDR_W'(n))) begin
        out_data_d[n*DATA_WIDTH +: DATA_WIDTH] = bus.neu_result;
      end
    end

    cap_cnt_d = accept_c ? '0 : cap_cnt_next_c;
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      wmem_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      issue_idx_q <= '0;
      cap_cnt_q   <= '0;
      neu_data_q  <= '0;
      out_data_q  <= '0;
      pipe_v_q    <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        pipe_i_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      wmem_en_q   <= wmem_en_d;
      busy_q      <= busy_d;
      issue_idx_q <= issue_idx_d;
      cap_cnt_q   <= cap_cnt_d;
      neu_data_q  <= neu_data_d;
      out_data_q  <= out_data_d;
      pipe_v_q    <= pipe_v_d;
      for (int k = 0; k < int'(DEPTH); k++) begin
        pipe_i_q[k] <= pipe_i_d[k];
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.wmem_en   = wmem_en_q;
  assign bus.wmem_addr = ADDR_W'(issue_idx_q);
  assign bus.busy      = busy_q;
  assign bus.neu_data  = neu_data_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Bench for neuron_layer_sequencer: three configurations (NN=4/LAT=0,
// NN=4/LAT=2, NN=1/LAT=0) driven side by side, each with a weight memory,
// a Neuron stand-in, and a transaction-level reference model.
module tb_neuron_layer_sequencer;
  localparam int DW = 8;
  localparam int NI = 2;
  localparam int IW = DW * NI;

  logic clk;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL inst%0d %s cycle=%0d actual=%0h required=%0h", inst, nm, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int NN  = (g == 2) ? 1 : 4;
    localparam int LAT = (g == 1) ? 2 : 0;
    localparam int D   = LAT + 1;
    localparam int AW  = (NN > 1) ? $clog2(NN) : 1;
    localparam int OW  = DW * NN;
    // Hand-computed pins: out_valid latency, back-to-back period, directed result
    localparam int PIN_RISE   = (g == 0) ? 6 : (g == 1) ? 8 : 3;
    localparam int PIN_PERIOD = (g == 0) ? 8 : (g == 1) ? 10 : 5;
    localparam logic [63:0] PIN_DATA = (g == 2) ? 64'h10 : 64'h13121110;

    logic rst_g;
    bit   pin = 1'b0;
    bit   b2b = 1'b0;

    neuron_layer_sequencer_if #(
      .DATA_WIDTH(DW), .NUM_INPUTS(NI), .NUM_NEURONS(NN), .ADDR_W(AW)
    ) bus ();

    neuron_layer_sequencer #(
      .DATA_WIDTH(DW), .NUM_INPUTS(NI), .NUM_NEURONS(NN),
      .NEURON_LAT(LAT), .ADDR_W(AW)
    ) dut (
      .clk (clk),
      .rst (rst_g),
      .bus (bus)
    );

    // Weight row n holds 0x10+n; Neuron adds the two input lanes to it
    logic [DW-1:0] mem_q = '0;
    logic [DW-1:0] nrn_c;
    always @(posedge clk) if (bus.wmem_en) mem_q <= 8'h10 + 8'(bus.wmem_addr);
    assign nrn_c = mem_q + bus.neu_data[7:0] + bus.neu_data[15:8];

    if (LAT == 0) begin : g_comb
      assign bus.neu_result = nrn_c;
    end else begin : g_pipe
      logic [DW-1:0] lat_q [LAT];
      always @(posedge clk) begin
        lat_q[0] <= nrn_c;
        for (int k = 1; k < LAT; k++) lat_q[k] <= lat_q[k-1];
      end
      assign bus.neu_result = lat_q[LAT-1];
    end

    function automatic logic [OW-1:0] expect_vec(input logic [IW-1:0] v);
      logic [OW-1:0] r;
      r = '0;
      for (int n = 0; n < NN; n++) r[n*DW +: DW] = 8'(8'h10 + n) + v[7:0] + v[15:8];
      return r;
    endfunction

    // Reference model: t counts cycles since accept; DONE is t==NN+D+1
    bit            m_armed = 1'b0;
    bit            m_idle  = 1'b1;
    bit            m_rdy   = 1'b1;
    int            m_t     = 0;
    logic [OW-1:0] m_exp   = '0;
    logic [IW-1:0] m_nd    = '0;

    always @(posedge clk) begin
      if (rst_g) begin
        m_armed = 1'b1;
        m_idle  = 1'b1;
        m_rdy   = 1'b1;
        m_t     = 0;
        m_nd    = '0;
      end else if (m_idle) begin
        if (m_rdy && bus.in_valid) begin
          m_idle = 1'b0;
          m_rdy  = 1'b0;
          m_t    = 1;
          m_nd   = bus.in_data;
          m_exp  = expect_vec(bus.in_data);
        end else begin
          m_rdy = 1'b1;
        end
      end else if (m_t == NN + D + 1) begin
        if (bus.out_ready) begin
          m_idle = 1'b1;
          m_rdy  = 1'b0;
        end
      end else begin
        m_t++;
      end
    end

    // Compare DUT against the model every cycle, mid-cycle
    bit   prev_ov  = 1'b0;
    bit   rst_prev = 1'b0;
    int   acc_cyc  = 0;
    int   last_acc = -1;
    logic e_en, e_ov, e_busy, e_rdy;
    int   e_addr;

    always @(negedge clk) begin
      if (m_armed) begin
        e_busy = !m_idle;
        e_rdy  = m_idle && m_rdy;
        e_en   = !m_idle && (m_t >= 1) && (m_t <= NN);
        e_addr = e_en ? (m_t - 1) : 0;
        e_ov   = !m_idle && (m_t == NN + D + 1);
        chk("in_ready",  g, 64'(bus.in_ready),  64'(e_rdy));
        chk("busy",      g, 64'(bus.busy),      64'(e_busy));
        chk("wmem_en",   g, 64'(bus.wmem_en),   64'(e_en));
        chk("wmem_addr", g, 64'(bus.wmem_addr), 64'(e_addr));
        chk("out_valid", g, 64'(bus.out_valid), 64'(e_ov));
        chk("neu_data",  g, 64'(bus.neu_data),  64'(m_nd));
        if (e_ov) chk("out_data", g, 64'(bus.out_data), 64'(m_exp));

        if (rst_prev) begin
          chk("rst_in_ready",  g, 64'(bus.in_ready),  64'd1);
          chk("rst_busy",      g, 64'(bus.busy),      64'd0);
          chk("rst_wmem_en",   g, 64'(bus.wmem_en),   64'd0);
          chk("rst_out_valid", g, 64'(bus.out_valid), 64'd0);
        end

        if (!rst_g && bus.in_valid && bus.in_ready) begin
          if (b2b && last_acc >= 0) chk("b2b_period", g, 64'(cyc - last_acc), 64'(PIN_PERIOD));
          last_acc = cyc;
          acc_cyc  = cyc;
        end
        if (!b2b) last_acc = -1;

        if (pin && !prev_ov && bus.out_valid) begin
          chk("rise_latency", g, 64'(cyc - acc_cyc), 64'(PIN_RISE));
          chk("pin_out_data", g, 64'(bus.out_data), PIN_DATA);
        end
      end
      prev_ov  = bus.out_valid;
      rst_prev = rst_g;
    end

    task automatic tick(input int n);
      repeat (n) begin
        @(posedge clk);
        #1;
      end
    endtask

    // Stimulus: directed pins, stall in DONE, mid-run reset, random, back-to-back
    initial begin
      rst_g         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      tick(3);
      rst_g = 1'b0;
      tick(1);

      pin          = 1'b1;
      bus.in_data  = '0;
      bus.in_valid = 1'b1;
      tick(1);
      bus.in_valid = 1'b0;
      tick(NN + D + 5);
      bus.in_valid = 1'b1;
      bus.in_data  = IW'($urandom);
      tick(10);
      bus.in_valid = 1'b0;
      tick(8);
      bus.out_ready = 1'b1;
      tick(1);
      bus.out_ready = 1'b0;
      pin = 1'b0;
      tick(3);

      bus.in_data  = IW'($urandom);
      bus.in_valid = 1'b1;
      tick(1);
      bus.in_valid = 1'b0;
      tick(2);
      rst_g = 1'b1;
      tick(1);
      rst_g = 1'b0;
      tick(3);
      bus.in_data   = IW'($urandom);
      bus.in_valid  = 1'b1;
      tick(1);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick(NN + D + 4);
      bus.out_ready = 1'b0;

      for (int i = 0; i < 400; i++) begin
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.in_data   = IW'($urandom);
        bus.out_ready = ($urandom_range(0, 3) != 0);
        rst_g         = ($urandom_range(0, 63) == 0);
        tick(1);
      end
      rst_g = 1'b0;

      b2b           = 1'b1;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 80; i++) begin
        bus.in_data = IW'($urandom);
        tick(1);
      end
      b2b          = 1'b0;
      bus.in_valid = 1'b0;
      tick(5);
    end
  end

  initial begin
    repeat (700) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
